v15_filter_event_ctrl: RTL and testbench
========================================

Name: v15_filter_event_ctrl

Overview:
- Sequencer and event extractor placed directly after the v15 trapezoidal filter.
- Drives the filter's active-low reset and masks the filter's pipeline-fill transient after every (re)start.
- Arms on a programmable threshold, tracks the pulse peak over the above-threshold window, and hands one event per pulse (peak, timestamp, width, pileup flag) to the readout through a valid/ready handshake.

Parameters:
- DATA_W, SIZE_FILTER_DATA, width of filter output samples (benches run 16).
- SETTLE_CYCLES, 32, cycles after filter reset release during which samples are ignored (≥ v15_k+v15_l+pipeline depth).
- MAX_WIDTH, 255, above-threshold window length at which a pulse is flagged pileup and closed.
- HOLDOFF, 8, dead cycles after an event is accepted before re-arming.
- TS_W, 32, timestamp counter width.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- reset, in, 1, asynchronous active-low reset.
- enable, in, 1, run control; 0 forces IDLE_OFF.
- restart, in, 1, single-cycle pulse: reset the filter and re-settle.
- threshold, in, DATA_W, trigger level (unsigned); sampled only in ARMED.
- filter_data, in, DATA_W, filter output sample (one per clk).
- filter_reset, out, 1, active-low reset to filter; 0 while held.
- event_valid, out, 1, event available.
- event_ready, in, 1, consumer accepts event.
- event_peak, out, DATA_W, max sample in window.
- event_ts, out, TS_W, timestamp of first above-threshold sample.
- event_width, out, 8, samples above threshold (saturates 255).
- event_pileup, out, 1, window reached MAX_WIDTH.
- drop_count, out, 16, pulses lost while busy (saturating).
- busy, out, 1, state ≠ ARMED.

Behaviour:
- Reset (async, reset=0):
  - state=FRST; filter_reset=0; event_valid=0.
  - All event fields=0; drop_count=0; timestamp=0; busy=1.
- Timestamp: free-running counter, +1 each clk from reset release, wraps modulo 2^TS_W, never stops.
- Above-threshold test: filter_data > threshold, strict, unsigned.
- States:
  - IDLE_OFF: filter_reset=1, ignore data. enable=1 → FRST.
  - FRST: filter_reset=0 for exactly 1 cycle → SETTLE with counter=0.
  - SETTLE: count SETTLE_CYCLES; data ignored; at count=SETTLE_CYCLES-1 → ARMED.
  - ARMED: busy=0. Above-threshold sample → RISE, capturing:
    - peak=sample, ts=current timestamp, width=1.
  - RISE, each cycle:
    - Sample above threshold: width+=1 (saturating); peak=max(peak,sample).
    - Sample ≤ threshold: → EMIT.
    - width reaching MAX_WIDTH: pileup=1 → EMIT; remaining above-threshold samples are ignored until data drops below threshold.
  - EMIT: event_valid=1; fields stable until handshake. event_valid & event_ready in the same cycle → HOLDOFF; event_valid drops the next cycle.
  - HOLDOFF: wait HOLDOFF cycles.
    - If the pileup tail is still above threshold at the end, remain in HOLDOFF until data ≤ threshold.
    - Then → ARMED.
- Latency: event_valid rises 1 clk after the first sample ≤ threshold (or after the MAX_WIDTH sample).
- Dropped pulses:
  - Counted in EMIT/HOLDOFF: each rising transition (previous sample ≤ threshold, current > threshold) increments drop_count.
  - drop_count saturates at 0xFFFF.
  - The pileup tail itself is not counted.
- restart:
  - Any state except IDLE_OFF → FRST next cycle.
  - A pending event is discarded: event_valid cleared, not counted as dropped.
  - restart takes priority over the handshake in the same cycle.
- enable=0 in any state → IDLE_OFF next cycle; pending event discarded.
- Async reset mid-operation returns to the reset values immediately; no event is emitted.
- Threshold changes during RISE take effect only at the next ARMED.

Test Plan:
- Startup: reset release, enable=1 → filter_reset=0 for exactly cycle 1; first sample honoured at cycle 1+SETTLE_CYCLES; threshold crossings before that produce no event.
- Single pulse: threshold=100; data 50,120,300,250,90; event_ready=1 → one event with peak=300, width=3, pileup=0, ts=timestamp of the 120 sample; event_valid high 1 clk after the 90 sample.
- Backpressure and drop: event_ready=0 for 40 cycles; two further pulses arrive → event fields stay constant; drop_count=2; after ready, HOLDOFF=8 cycles, then the next pulse is captured.
- Pileup: data held at 500 for 300 cycles with threshold=100 → event at width=255 with pileup=1; no re-arm until data ≤100; drop_count unchanged.
- Restart and reset mid-event: restart during EMIT → event_valid=0 next cycle and FRST/SETTLE replayed; async reset during RISE → all outputs at reset values in the same cycle.
- Timestamp wrap: TS_W=8, pulses 200 cycles apart → event_ts wraps modulo 256.

Source files
------------

// File: rtl/v15_filter_event_ctrl.sv
// v15_filter_event_ctrl: sequences the trapezoidal filter's reset and settle time, then extracts one event per pulse.
module v15_filter_event_ctrl #(
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 32,
    parameter int MAX_WIDTH     = 255,
    parameter int HOLDOFF       = 8,
    parameter int TS_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] filter_data,
    output logic              filter_reset,
    output logic              event_valid,
    input  logic              event_ready,
    output logic [DATA_W-1:0] event_peak,
    output logic [TS_W-1:0]   event_ts,
    output logic [7:0]        event_width,
    output logic              event_pileup,
    output logic [15:0]       drop_count,
    output logic              busy
);
    localparam int CNT_MAX = SETTLE_CYCLES > HOLDOFF ? SETTLE_CYCLES : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE_OFF = 3'd0;
    localparam logic [2:0] S_FRST     = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_ARMED    = 3'd3;
    localparam logic [2:0] S_RISE     = 3'd4;
    localparam logic [2:0] S_EMIT     = 3'd5;
    localparam logic [2:0] S_HOLDOFF  = 3'd6;

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] thr_q;
    logic              prev_above;
    logic              above_live, above_q, above;

    // live threshold only counts while armed; afterwards the level latched at arming is used
    assign above_live   = filter_data > threshold;
    assign above_q      = filter_data > thr_q;
    assign above        = (state == S_ARMED) ? above_live : above_q;
    assign filter_reset = state != S_FRST;
    assign busy         = state != S_ARMED;
    assign event_valid  = state == S_EMIT;

    // next state: enable dominates, then restart, then normal sequencing
    always_comb begin
        state_nx = state;
        if (!enable)
            state_nx = S_IDLE_OFF;
        else if (restart && state != S_IDLE_OFF)
            state_nx = S_FRST;
        else
            case (state)
                S_IDLE_OFF: state_nx = S_FRST;
                S_FRST:     state_nx = S_SETTLE;
                S_SETTLE:   state_nx = (cnt == CNT_W'(SETTLE_CYCLES - 1)) ? S_ARMED : S_SETTLE;
                S_ARMED:    state_nx = above_live ? S_RISE : S_ARMED;
                S_RISE:     state_nx = (!above_q || event_width >= 8'(MAX_WIDTH - 1)) ? S_EMIT : S_RISE;
                S_EMIT:     state_nx = event_ready ? S_HOLDOFF : S_EMIT;
                S_HOLDOFF:  state_nx = (cnt >= CNT_W'(HOLDOFF - 1) && !above_q) ? S_ARMED : S_HOLDOFF;
                default:    state_nx = S_IDLE_OFF;
            endcase
    end

    // state, phase counter (cleared on every state change), timestamp, latched threshold, previous compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FRST;
            cnt        <= '0;
            ts         <= '0;
            thr_q      <= '0;
            prev_above <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= (state_nx != state) ? '0 : (&cnt ? cnt : cnt + 1'b1);
            ts         <= ts + 1'b1;
            thr_q      <= (state == S_ARMED) ? threshold : thr_q;
            prev_above <= above;
        end
    end

    // event capture on arming, peak/width tracking while the pulse stays above threshold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_peak   <= '0;
            event_ts     <= '0;
            event_width  <= '0;
            event_pileup <= 1'b0;
        end else if (state == S_ARMED && state_nx == S_RISE) begin
            event_peak   <= filter_data;
            event_ts     <= ts;
            event_width  <= 8'd1;
            event_pileup <= 1'b0;
        end else if (state == S_RISE && above_q) begin
            event_peak   <= (filter_data > event_peak) ? filter_data : event_peak;
            event_width  <= &event_width ? event_width : event_width + 8'd1;
            event_pileup <= event_width >= 8'(MAX_WIDTH - 1);
        end
    end

    // pulses starting while an event is pending or in holdoff are lost; a pileup tail has no rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_count <= '0;
        else if ((state == S_EMIT || state == S_HOLDOFF) && above_q && !prev_above && !(&drop_count))
            drop_count <= drop_count + 16'd1;
    end
endmodule

// File: tb/tb_v15_filter_event_ctrl.sv
// tb_v15_filter_event_ctrl: directed table and sequence checks for the filter event controller.
module tb_v15_filter_event_ctrl;
    logic        clk = 1'b0;
    logic        reset, enable, restart, event_ready;
    logic [15:0] threshold, filter_data;
    logic        filter_reset, event_valid, event_pileup, busy;
    logic [15:0] event_peak, drop_count;
    logic [7:0]  event_ts, event_width;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          edges = 0;
    logic [7:0]  exp_ts;

    typedef struct {
        logic [15:0] data;
        logic        rdy;
        logic        mark;
        logic        valid;
        logic        bsy;
        logic [15:0] peak;
        logic [7:0]  width;
    } vec_t;

    vec_t tbl[$];

    v15_filter_event_ctrl #(
        .DATA_W(16), .SETTLE_CYCLES(32), .MAX_WIDTH(255), .HOLDOFF(8), .TS_W(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .threshold(threshold), .filter_data(filter_data), .filter_reset(filter_reset),
        .event_valid(event_valid), .event_ready(event_ready), .event_peak(event_peak),
        .event_ts(event_ts), .event_width(event_width), .event_pileup(event_pileup),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic wait_armed(input int lim);
        int k = 0;
        while (busy && k < lim) begin
            tick;
            k++;
        end
        chk("arm_timeout", {31'd0, busy}, 0);
    endtask

    task automatic push(input int d, input bit r, input bit m, input bit v, input bit b, input int p, input int w);
        tbl.push_back('{16'(d), r, m, v, b, 16'(p), 8'(w)});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; restart = 1'b0; event_ready = 1'b0;
        threshold = 16'd100; filter_data = 16'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_filter_reset", {31'd0, filter_reset}, 0);
        chk("rst_valid", {31'd0, event_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_fields", {event_peak, event_width, event_ts}, 0);
        chk("rst_pileup_drop", {event_pileup, drop_count}, 0);

        // startup: filter reset for one cycle, samples above threshold ignored while settling
        reset = 1'b1;
        edges = 0;
        chk("start_frst", {31'd0, filter_reset}, 0);
        tick;
        chk("start_frst_released", {31'd0, filter_reset}, 1);
        filter_data = 16'd1000;
        for (int k = 2; k <= 33; k++) begin
            tick;
            if (k == 32) chk("settle_last_busy", {31'd0, busy}, 1);
            if (k == 33) chk("settle_armed", {31'd0, busy}, 0);
        end
        filter_data = 16'd0;
        tick; tick;
        chk("settle_no_event", {30'd0, event_valid, busy}, 0);

        // single pulse, holdoff, then a pulse at exactly threshold vs threshold+1
        push(50, 1, 0, 0, 0, 0, 0);
        push(120, 1, 1, 0, 1, 0, 0);
        push(300, 1, 0, 0, 1, 0, 0);
        push(250, 1, 0, 0, 1, 0, 0);
        push(90, 1, 0, 1, 1, 300, 3);
        for (int k = 0; k < 8; k++) push(0, 1, 0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0);
        push(100, 1, 0, 0, 0, 0, 0);
        push(101, 1, 1, 0, 1, 0, 0);
        push(101, 1, 0, 0, 1, 0, 0);
        push(100, 1, 0, 1, 1, 101, 2);
        for (int k = 0; k < 8; k++) push(0, 1, 0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            filter_data = tbl[i].data;
            event_ready = tbl[i].rdy;
            if (tbl[i].mark) exp_ts = 8'(edges);
            tick;
            chk($sformatf("row%0d_valid", i), {31'd0, event_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            if (tbl[i].valid) begin
                chk($sformatf("row%0d_peak", i), {16'd0, event_peak}, {16'd0, tbl[i].peak});
                chk($sformatf("row%0d_width_pileup", i), {event_pileup, event_width}, {1'b0, tbl[i].width});
                chk($sformatf("row%0d_ts", i), {24'd0, event_ts}, {24'd0, exp_ts});
            end
        end
        chk("table_drops", {16'd0, drop_count}, 0);

        // backpressure: event held 40 cycles while two further pulses are dropped
        event_ready = 1'b0;
        filter_data = 16'd200; exp_ts = 8'(edges); tick;
        filter_data = 16'd400; tick;
        filter_data = 16'd50; tick;
        chk("bp_event", {event_valid, event_peak, event_width}, {1'b1, 16'd400, 8'd2});
        chk("bp_ts", {24'd0, event_ts}, {24'd0, exp_ts});
        for (int i = 0; i < 40; i++) begin
            filter_data = (i >= 5 && i < 8) ? 16'd150 : (i >= 13 && i < 15) ? 16'd600 : 16'd0;
            tick;
            chk("bp_hold", {event_valid, event_peak, event_width}, {1'b1, 16'd400, 8'd2});
        end
        chk("bp_drops", {16'd0, drop_count}, 2);
        event_ready = 1'b1;
        filter_data = 16'd0;
        tick;
        chk("bp_accept", {31'd0, event_valid}, 0);
        repeat (7) tick;
        chk("bp_holdoff_busy", {31'd0, busy}, 1);
        tick;
        chk("bp_holdoff_done", {31'd0, busy}, 0);
        filter_data = 16'd300; exp_ts = 8'(edges); tick;
        filter_data = 16'd0; tick;
        chk("bp_next_event", {event_valid, event_peak, event_width}, {1'b1, 16'd300, 8'd1});
        chk("bp_next_ts", {24'd0, event_ts}, {24'd0, exp_ts});
        tick;
        wait_armed(20);

        // pileup: long pulse closes at MAX_WIDTH, tail keeps holdoff, nothing dropped
        filter_data = 16'd500;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (i == 253) chk("pu_before", {31'd0, event_valid}, 0);
            if (i == 254) chk("pu_event", {event_valid, event_pileup, event_width, event_peak}, {1'b1, 1'b1, 8'd255, 16'd500});
            if (i == 255) chk("pu_accept", {31'd0, event_valid}, 0);
            if (i == 299) chk("pu_tail_busy", {30'd0, event_valid, busy}, 1);
        end
        filter_data = 16'd50;
        tick;
        chk("pu_rearm", {31'd0, busy}, 0);
        chk("pu_drops", {16'd0, drop_count}, 2);

        // restart during a pending event discards it and replays reset/settle
        event_ready = 1'b0;
        filter_data = 16'd200; tick;
        filter_data = 16'd0; tick;
        chk("rs_pending", {31'd0, event_valid}, 1);
        restart = 1'b1; event_ready = 1'b1;
        tick;
        restart = 1'b0;
        chk("rs_discard", {30'd0, event_valid, filter_reset}, 0);
        tick;
        chk("rs_settle", {30'd0, filter_reset, busy}, 3);
        repeat (31) tick;
        chk("rs_settle_last", {31'd0, busy}, 1);
        tick;
        chk("rs_armed", {31'd0, busy}, 0);
        chk("rs_drops", {16'd0, drop_count}, 2);

        // asynchronous reset in the middle of a pulse
        filter_data = 16'd300;
        tick;
        chk("ar_rise", {31'd0, busy}, 1);
        #3 reset = 1'b0;
        #1;
        chk("ar_outputs", {filter_reset, event_valid, busy, event_pileup}, 4'b0010);
        chk("ar_fields", {event_peak, event_width, event_ts}, 0);
        chk("ar_drops", {16'd0, drop_count}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        edges = 0;
        filter_data = 16'd0;
        wait_armed(40);

        // timestamp wraps modulo 2^8
        while (edges < 100) tick;
        exp_ts = 8'd100;
        filter_data = 16'd200; tick;
        filter_data = 16'd0; tick;
        chk("ts_first", {23'd0, event_valid, event_ts}, {23'd0, 1'b1, exp_ts});
        tick;
        while (edges < 300) tick;
        exp_ts = 8'd44;
        filter_data = 16'd200; tick;
        filter_data = 16'd0; tick;
        chk("ts_wrapped", {23'd0, event_valid, event_ts}, {23'd0, 1'b1, exp_ts});
        tick;

        // enable low parks the controller with the filter out of reset, enable high restarts
        wait_armed(20);
        enable = 1'b0;
        tick;
        chk("en_off", {30'd0, filter_reset, busy}, 3);
        tick;
        enable = 1'b1;
        tick;
        chk("en_frst", {31'd0, filter_reset}, 0);
        tick;
        chk("en_settle", {30'd0, filter_reset, busy}, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
